uart_tx_responder: RTL
======================

Name: uart_tx_responder

Overview:
Memory-mapped UART transmitter peripheral. It responds to the CPU MEM-stage bus, the initiator side that drives MemRd/MemWr, address and store data. CPU stores to TXD queue bytes in a small FIFO, and an 8N1 serializer shifts them out on uart_tx. The CON register supplies status and interrupt enable, and the block raises a level interrupt toward the CPU IRQ logic.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD (integer, >=2) cycles per bit
FIFO_DEPTH, 4, TX byte FIFO entries (power of two, >=2)
TXD_ADDR, 32'h40000018, transmit data register address
CON_ADDR, 32'h40000020, control/status register address

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
MemRd  input  1  bus read strobe, one cycle per access
MemWr  input  1  bus write strobe, one cycle per access
Addr  input  32  byte address of the access
WriteData  input  32  store data; bits [7:0] used
ReadData  output  32  combinational read data; 0 when not selected
uart_tx  output  1  serial line, idle high
irq_tx  output  1  level interrupt = done_flag & irq_en

Behaviour:
- Reset is asynchronous and active-high: uart_tx=1, irq_tx=0, FIFO empty, FSM=IDLE, irq_en=0, done_flag=0, ovf_flag=0, last_txd=0, baud counter=0, bit index=0.
- Write TXD (MemWr & Addr==TXD_ADDR): push WriteData[7:0] and load last_txd.
  - Push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and ovf_flag is set.
- Write CON: irq_en <= WriteData[0]. Other bits are ignored.
- Read TXD: ReadData = {24'b0, last_txd}.
- Read CON: ReadData = {27'b0, ovf_flag, busy, done_flag, 1'b0, irq_en}, bit layout [4]=ovf, [3]=busy, [2]=done, [0]=irq_en.
  - busy = (FSM!=IDLE) | FIFO non-empty.
  - A read of CON clears done_flag and ovf_flag at the clock edge. If a set event occurs in the same cycle, the set wins.
- Any other address: ReadData=0 and writes have no effect. MemRd and MemWr together in one cycle is illegal; if it occurs, the write is performed.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop into the shift register, clear the counter and go to START.
  - START: uart_tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0], LSB first. Each bit lasts DIV cycles. After bit 7, go to STOP.
  - STOP: uart_tx=1 for DIV cycles, then set done_flag. If the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- uart_tx is registered and glitch-free.
- Latency: a TXD write at edge E0 makes the FIFO non-empty. At E1 the FSM enters START, and uart_tx is low from just after E1.
- Frame length is 10*DIV cycles. done_flag rises at the edge ending the stop bit.
- FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Reset mid-frame: the line returns high immediately and queued bytes are discarded.

Decomposition:
- Shared package (uart_pkg): TXD_ADDR and CON_ADDR constants, CON bit-position constants, and the tx FSM state enum (2-bit encoding). The future RX peripheral reuses this package.
- One sub-module, uart_tx_fifo: synchronous FIFO with push, pop, full, empty, count and async reset. The serializer and register decode stay in the top module.

Test Plan:
Bench uses CLK_FREQ=1000, BAUD=100 (DIV=10).
- Reset then idle: after reset deassert, uart_tx=1, irq_tx=0, and a CON read returns 0x00000000 for 50 cycles.
- Single byte 0x55: one write to TXD. uart_tx is low for cycles 1-10 after the write edge, then sends 1,0,1,0,1,0,1,0 at 10 cycles each, then stop high. A CON read after 101 cycles returns 0x04; the next CON read returns 0x00.
- Interrupt: write CON=1, then write TXD=0xA3. irq_tx rises at cycle 101. A CON read returns 0x05 and irq_tx drops on the following edge.
- Back-to-back frames: write 0x01, 0x02, 0x03 on consecutive cycles. Three frames go out contiguously over 300 cycles with no idle gap. CON bit3=1 until the final stop bit ends.
- Overflow: write 6 bytes on consecutive cycles with FIFO_DEPTH=4.
  - Byte 1 is popped at E1, so bytes 1-5 are accepted and byte 6 is dropped.
  - CON reads 0x18 (ovf plus busy). Exactly 5 frames are observed.
- Reset mid-frame: assert reset during DATA bit 3. uart_tx=1 asynchronously, and after release no further frames appear and CON=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bus register map, CON bit layout and the TX FSM state type.
package uart_pkg;

  localparam logic [31:0] TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] CON_ADDR = 32'h4000_0020;

  localparam int unsigned CON_IRQ_EN_BIT = 0;
  localparam int unsigned CON_DONE_BIT   = 2;
  localparam int unsigned CON_BUSY_BIT   = 3;
  localparam int unsigned CON_OVF_BIT    = 4;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter: TXD/CON register decode, byte FIFO and a
// registered serializer with back-to-back frame chaining and a level interrupt.
module uart_tx_responder #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] TXD_ADDR   = uart_pkg::TXD_ADDR,
  parameter logic [31:0] CON_ADDR   = uart_pkg::CON_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_tx,
  output logic        irq_tx
);

  import uart_pkg::*;

  localparam int unsigned DIV      = CLK_FREQ / BAUD;
  localparam int unsigned CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNTW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  tx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  last_txd_q, last_txd_d;

  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CNTW-1:0] fifo_count;
  logic            done_set, bit_end, busy;
  logic            rd_en, txd_wr, con_wr, txd_rd, con_rd;
  logic            unused_wdata;

  assign unused_wdata = ^WriteData[31:8];

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (txd_wr),
    .pop  (fifo_pop),
    .din  (WriteData[7:0]),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Bus decode; a simultaneous read and write is treated as the write alone
  always_comb begin
    rd_en  = MemRd & ~MemWr;
    txd_wr = MemWr & (Addr == TXD_ADDR);
    con_wr = MemWr & (Addr == CON_ADDR);
    txd_rd = rd_en & (Addr == TXD_ADDR);
    con_rd = rd_en & (Addr == CON_ADDR);
  end

  assign bit_end = (cnt_q == CNT_LAST);
  assign busy    = (state_q != TX_IDLE) | (fifo_count != '0);

  // Serializer next state; tx_d is the line level for the state being entered
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    done_set  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = '0;
          state_d  = TX_START;
          tx_d     = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = TX_DATA;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          cnt_d    = '0;
          done_set = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = TX_START;
            tx_d     = 1'b0;
          end else begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Register-file next state; a CON read clears sticky flags unless set this cycle
  always_comb begin
    last_txd_d = txd_wr ? WriteData[7:0] : last_txd_q;
    irq_en_d   = con_wr ? WriteData[0]   : irq_en_q;
    done_d     = done_set | (done_q & ~con_rd);
    ovf_d      = (txd_wr & fifo_full & ~fifo_pop) | (ovf_q & ~con_rd);
  end

  // Combinational read mux
  always_comb begin
    ReadData = '0;
    if (con_rd) begin
      ReadData[CON_OVF_BIT]    = ovf_q;
      ReadData[CON_BUSY_BIT]   = busy;
      ReadData[CON_DONE_BIT]   = done_q;
      ReadData[CON_IRQ_EN_BIT] = irq_en_q;
    end else if (txd_rd) begin
      ReadData = {24'b0, last_txd_q};
    end
  end

  // State registers; the line is forced idle-high as soon as reset asserts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      last_txd_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      last_txd_q <= last_txd_d;
    end
  end

  assign uart_tx = tx_q;
  assign irq_tx  = done_q & irq_en_q;

endmodule
